// File: rtl/sub_pkg.sv
// Shared types and elaboration limits for the bit-serial subtractor.
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   localparam int MIN_WIDTH = 2;

   function automatic bit width_legal(input int w);
      return (w >= MIN_WIDTH);
   endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: diff = a - b - bin, with borrow out.
module fs_cell
   import sub_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b - bin over WIDTH bits, LSB first, one bit per clock,
// with start/busy/done handshake and signed-overflow flag.
module serial_sub
   import sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   generate
      if (!width_legal(WIDTH)) begin : g_width_chk
         $error("serial_sub: WIDTH must be at least %0d", MIN_WIDTH);
      end
   endgenerate

   sub_state_t       state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_r;
   logic [CW-1:0]    cnt_r;
   logic             brw_r;
   logic             bout_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;
   logic             d_s;
   logic             bo_s;

   fs_cell u_cell (
      .a    (a_sh_r[0]),
      .b    (b_sh_r[0]),
      .bin  (brw_r),
      .diff (d_s),
      .bout (bo_s)
   );

   // Control FSM, operand shifters, bit counter and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         a_sh_r  <= '0;
         b_sh_r  <= '0;
         res_r   <= '0;
         cnt_r   <= '0;
         brw_r   <= 1'b0;
         bout_r  <= 1'b0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_sh_r  <= a;
                  b_sh_r  <= b;
                  brw_r   <= bin;
                  cnt_r   <= '0;
                  res_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            RUN: begin
               res_r  <= {d_s, res_r[WIDTH-1:1]};
               a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
               brw_r  <= bo_s;
               busy_r <= 1'b1;
               // Overflow is borrow into the MSB XOR borrow out of it; counter stops at the last bit.
               if (cnt_r == LAST_CNT) begin
                  ovf_r   <= brw_r ^ bo_s;
                  bout_r  <= bo_s;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  cnt_r   <= cnt_r + CW'(1);
                  done_r  <= 1'b0;
                  state_r <= RUN;
               end
            end
            DONE: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign diff = res_r;
   assign bout = bout_r;
   assign ovf  = ovf_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub at WIDTH=8 and WIDTH=2 against a
// timeline/arithmetic reference model.
module tb_serial_sub;

   logic       clk;
   logic [1:0] rst_v, start_v, bin_v;
   logic [7:0] a_v [2];
   logic [7:0] b_v [2];
   logic [7:0] diff_v [2];
   logic [1:0] busy_v, done_v, bout_v, ovf_v;

   logic [7:0] diff8;
   logic [1:0] diff2;
   logic       bout8, bout2, ovf8, ovf2, busy8, busy2, done8, done2;

   int compared   = 0;
   int mismatched = 0;
   int wid [2] = '{8, 2};

   // model state
   int cyc = 0;
   bit armed  [2] = '{1'b0, 1'b0};
   bit active [2] = '{1'b0, 1'b0};
   int t_start [2] = '{0, 0};
   int cur_d [2] = '{0, 0};
   int cur_bo [2] = '{0, 0};
   int cur_ov [2] = '{0, 0};
   int pen_d [2] = '{0, 0};
   int pen_bo [2] = '{0, 0};
   int pen_ov [2] = '{0, 0};

   serial_sub #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .bin(bin_v[0]),
      .diff(diff8), .bout(bout8), .ovf(ovf8), .busy(busy8), .done(done8));

   serial_sub #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_v[1][1:0]), .b(b_v[1][1:0]), .bin(bin_v[1]),
      .diff(diff2), .bout(bout2), .ovf(ovf2), .busy(busy2), .done(done2));

   assign diff_v[0] = diff8;
   assign diff_v[1] = {6'b0, diff2};
   assign bout_v = {bout2, bout8};
   assign ovf_v  = {ovf2, ovf8};
   assign busy_v = {busy2, busy8};
   assign done_v = {done2, done8};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: unsigned modular difference, unsigned borrow, signed range overflow.
   function automatic void ref_sub(input int w, input int a, input int b, input int bi,
                                   output int d, output int bo, output int ov);
      int m, sa, sb, sr;
      m  = 1 << w;
      d  = (a - b - bi + 2 * m) % m;
      bo = (a < b + bi) ? 1 : 0;
      sa = (a >= m / 2) ? a - m : a;
      sb = (b >= m / 2) ? b - m : b;
      sr = sa - sb - bi;
      ov = (sr < -(m / 2) || sr > m / 2 - 1) ? 1 : 0;
   endfunction

   // Model: at each edge, track accepted starts and when results become visible.
   initial forever begin
      @(posedge clk);
      cyc++;
      for (int u = 0; u < 2; u++) begin
         if (rst_v[u]) begin
            armed[u]  = 1'b1;
            active[u] = 1'b0;
            cur_d[u] = 0; cur_bo[u] = 0; cur_ov[u] = 0;
         end else begin
            if (start_v[u] && (!active[u] || cyc >= t_start[u] + wid[u] + 2)) begin
               t_start[u] = cyc;
               active[u]  = 1'b1;
               ref_sub(wid[u], int'(a_v[u]) % (1 << wid[u]), int'(b_v[u]) % (1 << wid[u]),
                       int'(bin_v[u]), pen_d[u], pen_bo[u], pen_ov[u]);
            end
            if (active[u] && cyc == t_start[u] + wid[u]) begin
               cur_d[u] = pen_d[u]; cur_bo[u] = pen_bo[u]; cur_ov[u] = pen_ov[u];
            end
         end
      end
   end

   // Compare: every cycle, busy/done always; results whenever not mid-operation.
   initial forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         if (armed[u]) begin
            bit run, eb, ed;
            run = active[u] && cyc >= t_start[u] && cyc < t_start[u] + wid[u];
            eb  = active[u] && cyc >= t_start[u] && cyc <= t_start[u] + wid[u];
            ed  = active[u] && cyc == t_start[u] + wid[u];
            chk($sformatf("w%0d busy", wid[u]), 32'(busy_v[u]), 32'(eb));
            chk($sformatf("w%0d done", wid[u]), 32'(done_v[u]), 32'(ed));
            if (!run) begin
               chk($sformatf("w%0d diff", wid[u]), 32'(diff_v[u]), 32'(cur_d[u]));
               chk($sformatf("w%0d bout", wid[u]), 32'(bout_v[u]), 32'(cur_bo[u]));
               chk($sformatf("w%0d ovf", wid[u]), 32'(ovf_v[u]), 32'(cur_ov[u]));
            end
         end
      end
   end

   // One operation on unit u from an idle DUT; returns results seen in the done cycle.
   task automatic do_op(input int u, input int a, input int b, input int bi,
                        output int dd, output int dbo, output int dov);
      int nb, nd, lat;
      bit seen;
      @(negedge clk);
      a_v[u] = 8'(a); b_v[u] = 8'(b); bin_v[u] = 1'(bi); start_v[u] = 1'b1;
      nb = 0; nd = 0; lat = 0; seen = 1'b0; dd = 0; dbo = 0; dov = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         start_v[u] = 1'b0;
         if (busy_v[u]) nb++;
         if (done_v[u]) begin
            nd++; seen = 1'b1; lat = i;
            dd = int'(diff_v[u]); dbo = int'(bout_v[u]); dov = int'(ovf_v[u]);
         end
      end
      @(negedge clk);
      if (busy_v[u]) nb++;
      if (done_v[u]) nd++;
      chk($sformatf("w%0d done_seen", wid[u]), 32'(seen), 32'd1);
      chk($sformatf("w%0d latency", wid[u]), 32'(lat), 32'(wid[u] + 1));
      chk($sformatf("w%0d busy_cycles", wid[u]), 32'(nb), 32'(wid[u] + 1));
      chk($sformatf("w%0d done_cycles", wid[u]), 32'(nd), 32'd1);
   endtask

   int tv_a  [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
   int tv_b  [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
   int tv_bi [5] = '{0, 0, 1, 0, 0};
   int ex_d  [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
   int ex_bo [5] = '{0, 1, 1, 0, 1};
   int ex_ov [5] = '{0, 0, 0, 1, 1};

   initial begin
      int d, bo, ov, nd, dd;
      rst_v = 2'b11; start_v = 2'b00; bin_v = 2'b00;
      a_v[0] = 8'h00; a_v[1] = 8'h00; b_v[0] = 8'h00; b_v[1] = 8'h00;

      // pin the reference model to hand-computed values
      for (int i = 0; i < 5; i++) begin
         ref_sub(8, tv_a[i], tv_b[i], tv_bi[i], d, bo, ov);
         chk($sformatf("model_d%0d", i), 32'(d), 32'(ex_d[i]));
         chk($sformatf("model_bo%0d", i), 32'(bo), 32'(ex_bo[i]));
         chk($sformatf("model_ov%0d", i), 32'(ov), 32'(ex_ov[i]));
      end

      repeat (3) @(negedge clk);
      chk("reset busy", 32'(busy8), 32'd0);
      chk("reset diff", 32'(diff8), 32'd0);
      rst_v = 2'b00;

      // directed vectors with literal expectations
      for (int i = 0; i < 5; i++) begin
         do_op(0, tv_a[i], tv_b[i], tv_bi[i], d, bo, ov);
         chk($sformatf("tp_diff%0d", i), 32'(d), 32'(ex_d[i]));
         chk($sformatf("tp_bout%0d", i), 32'(bo), 32'(ex_bo[i]));
         chk($sformatf("tp_ovf%0d", i), 32'(ov), 32'(ex_ov[i]));
      end

      // start pulsed mid-RUN with new operands is ignored
      @(negedge clk);
      a_v[0] = 8'h10; b_v[0] = 8'h01; bin_v[0] = 1'b0; start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      a_v[0] = 8'hAA; start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      nd = 0; dd = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8) begin nd++; dd = int'(diff8); end
      end
      chk("busy_start done_count", 32'(nd), 32'd1);
      chk("busy_start diff", 32'(dd), 32'h0F);

      // held start: back-to-back operations with changing operands
      @(negedge clk);
      start_v[0] = 1'b1;
      nd = 0;
      for (int i = 0; i < 32; i++) begin
         a_v[0] = 8'($urandom); b_v[0] = 8'($urandom); bin_v[0] = 1'($urandom);
         @(negedge clk);
         if (done8) nd++;
      end
      start_v[0] = 1'b0;
      chk("held_start done_count", 32'(nd), 32'd3);
      repeat (12) @(negedge clk);

      // reset at RUN cycle 4
      a_v[0] = 8'h37; b_v[0] = 8'h12; bin_v[0] = 1'b0; start_v[0] = 1'b1;
      @(negedge clk); start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_v[0] = 1'b1;
      @(negedge clk); rst_v[0] = 1'b0;
      chk("midrst busy", 32'(busy8), 32'd0);
      chk("midrst diff", 32'(diff8), 32'd0);
      chk("midrst bout", 32'(bout8), 32'd0);
      chk("midrst ovf", 32'(ovf8), 32'd0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done8) nd++;
      end
      chk("midrst no_done", 32'(nd), 32'd0);
      do_op(0, 8'h37, 8'h12, 0, d, bo, ov);
      chk("after_rst diff", 32'(d), 32'h25);

      // randomized operations with occasional aborting reset
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            a_v[0] = 8'($urandom); b_v[0] = 8'($urandom); bin_v[0] = 1'($urandom);
            start_v[0] = 1'b1;
            @(negedge clk); start_v[0] = 1'b0;
            repeat ($urandom_range(0, 8)) @(negedge clk);
            rst_v[0] = 1'b1;
            @(negedge clk); rst_v[0] = 1'b0;
         end else begin
            do_op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 1)), d, bo, ov);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // exhaustive WIDTH=2
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int bi = 0; bi < 2; bi++) begin
               int rd, rbo, rov;
               do_op(1, a, b, bi, d, bo, ov);
               ref_sub(2, a, b, bi, rd, rbo, rov);
               chk($sformatf("w2 a%0d b%0d bin%0d diff", a, b, bi), 32'(d), 32'(rd));
               chk($sformatf("w2 a%0d b%0d bin%0d bout", a, b, bi), 32'(bo), 32'(rbo));
               chk($sformatf("w2 a%0d b%0d bin%0d ovf", a, b, bi), 32'(ov), 32'(rov));
            end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete (compared %0d)", compared);
      $fatal(1, "watchdog expired");
   end

endmodule
